bt_msg_scheduler: RTL and testbench

Sequences status messages onto the single HC-05 UART byte transmitter. Three message sources (fault-identified FIM, pick-block PBM, end-of-run END) raise one-cycle request pulses; the block latches them, arbitrates by fixed priority, and streams the selected ASCII message byte-by-byte over a valid/ready handshake into the UART byte transmitter. It also enforces an idle gap between messages so the receiving side can frame them.

---
 rtl/bt_msg_pkg.sv | 35 +++
 rtl/bt_msg_rom.sv | 53 +++++
 rtl/bt_msg_scheduler.sv | 204 ++++++++++++++++++++
 tb/tb_bt_msg_scheduler.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bt_msg_pkg.sv
// Shared ASCII constants, message classes, lengths and FSM states for the
// Bluetooth status-message scheduler.
package bt_msg_pkg;

  localparam logic [7:0] CH_F    = 8'h46;
  localparam logic [7:0] CH_I    = 8'h49;
  localparam logic [7:0] CH_M    = 8'h4D;
  localparam logic [7:0] CH_P    = 8'h50;
  localparam logic [7:0] CH_B    = 8'h42;
  localparam logic [7:0] CH_E    = 8'h45;
  localparam logic [7:0] CH_N    = 8'h4E;
  localparam logic [7:0] CH_D    = 8'h44;
  localparam logic [7:0] CH_C    = 8'h43;
  localparam logic [7:0] CH_S    = 8'h53;
  localparam logic [7:0] CH_U    = 8'h55;
  localparam logic [7:0] CH_DASH = 8'h2D;
  localparam logic [7:0] CH_HASH = 8'h23;

  localparam logic [3:0] LEN_FIM = 4'd10;
  localparam logic [3:0] LEN_PBM = 4'd10;
  localparam logic [3:0] LEN_END = 4'd5;

  typedef enum logic [1:0] {FIM = 2'd0, PBM = 2'd1, END = 2'd2} msg_class_t;

  typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, GAP = 2'd2} sched_state_t;

  function automatic logic [3:0] msg_len(input msg_class_t cls);
    case (cls)
      FIM:     msg_len = LEN_FIM;
      PBM:     msg_len = LEN_PBM;
      default: msg_len = LEN_END;
    endcase
  endfunction

endpackage

// File: rtl/bt_msg_rom.sv
// Combinational message ROM: maps (class, byte index, unit) to the ASCII byte
// of the status message; indices past the message end read as 8'h00.
module bt_msg_rom
  import bt_msg_pkg::*;
#(
  parameter logic [7:0] DIGIT_BASE = 8'h31
) (
  input  logic [1:0] cls,
  input  logic [3:0] idx,
  input  logic [1:0] unit,
  output logic [7:0] byte_out
);

  msg_class_t cls_e;
  logic [7:0] digit;
  logic [7:0] tag0;
  logic [7:0] tag1;

  assign cls_e = msg_class_t'(cls);

  always_comb begin
    digit    = DIGIT_BASE + {6'd0, unit};
    tag0     = (cls_e == PBM) ? CH_P : CH_F;
    tag1     = (cls_e == PBM) ? CH_B : CH_I;
    byte_out = 8'h00;
    if (cls_e == END) begin
      case (idx)
        4'd0:    byte_out = CH_E;
        4'd1:    byte_out = CH_N;
        4'd2:    byte_out = CH_D;
        4'd3:    byte_out = CH_DASH;
        4'd4:    byte_out = CH_HASH;
        default: byte_out = 8'h00;
      endcase
    end else if (cls_e == FIM || cls_e == PBM) begin
      // FIM and PBM share the "xxM-CSUd-#" layout, differing only in the tag
      case (idx)
        4'd0:    byte_out = tag0;
        4'd1:    byte_out = tag1;
        4'd2:    byte_out = CH_M;
        4'd3:    byte_out = CH_DASH;
        4'd4:    byte_out = CH_C;
        4'd5:    byte_out = CH_S;
        4'd6:    byte_out = CH_U;
        4'd7:    byte_out = digit;
        4'd8:    byte_out = CH_DASH;
        4'd9:    byte_out = CH_HASH;
        default: byte_out = 8'h00;
      endcase
    end
  end

endmodule

// File: rtl/bt_msg_scheduler.sv
// Latches FIM/PBM/END message requests, grants them by fixed priority and
// streams each message byte-wise to the UART, with an idle gap between
// messages. Define BT_SCHED_DROP_CNT_EN to add the dropped-request counter.
module bt_msg_scheduler
  import bt_msg_pkg::*;
#(
  parameter int         GAP_CYCLES = 50000,
  parameter logic [7:0] DIGIT_BASE = 8'h31
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       fim_req,
  input  logic [1:0] fim_unit,
  input  logic       pbm_req,
  input  logic [1:0] pbm_unit,
  input  logic       end_req,
  output logic       fim_ack,
  output logic       pbm_ack,
  output logic       end_ack,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  input  logic       byte_ready,
  output logic       busy,
  output logic       msg_done
`ifdef BT_SCHED_DROP_CNT_EN
  ,
  output logic [7:0] drop_cnt
`endif
);

  localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;

  sched_state_t   state_q, state_d;
  msg_class_t     cls_q, cls_d;
  logic [1:0]     unit_q, unit_d;
  logic [3:0]     idx_q, idx_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic           fim_pend_q, fim_pend_d, pbm_pend_q, pbm_pend_d, end_pend_q, end_pend_d;
  logic [1:0]     fim_unit_q, fim_unit_d, pbm_unit_q, pbm_unit_d;
  logic           byte_valid_q, byte_valid_d;
  logic [7:0]     byte_data_q, byte_data_d;
  logic           fim_ack_q, fim_ack_d, pbm_ack_q, pbm_ack_d, end_ack_q, end_ack_d;
  logic           msg_done_q, msg_done_d;
  logic           grant_fim, grant_pbm, grant_end;
  logic [7:0]     rom_byte;

  // The ROM looks at the next-cycle selection so byte_data can be registered
  bt_msg_rom #(.DIGIT_BASE(DIGIT_BASE)) u_rom (
    .cls     (cls_d),
    .idx     (idx_d),
    .unit    (unit_d),
    .byte_out(rom_byte)
  );

  always_comb begin
    state_d      = state_q;
    cls_d        = cls_q;
    unit_d       = unit_q;
    idx_d        = idx_q;
    gap_d        = gap_q;
    byte_valid_d = byte_valid_q;
    fim_ack_d    = 1'b0;
    pbm_ack_d    = 1'b0;
    end_ack_d    = 1'b0;
    msg_done_d   = 1'b0;
    grant_fim    = 1'b0;
    grant_pbm    = 1'b0;
    grant_end    = 1'b0;

    case (state_q)
      IDLE: begin
        if (fim_pend_q) begin
          grant_fim = 1'b1;
          cls_d     = FIM;
          unit_d    = fim_unit_q;
          fim_ack_d = 1'b1;
        end else if (pbm_pend_q) begin
          grant_pbm = 1'b1;
          cls_d     = PBM;
          unit_d    = pbm_unit_q;
          pbm_ack_d = 1'b1;
        end else if (end_pend_q) begin
          grant_end = 1'b1;
          cls_d     = END;
          unit_d    = 2'd0;
          end_ack_d = 1'b1;
        end
        if (fim_pend_q || pbm_pend_q || end_pend_q) begin
          idx_d        = 4'd0;
          byte_valid_d = 1'b1;
          state_d      = SEND;
        end
      end
      SEND: begin
        if (byte_valid_q && byte_ready) begin
          if (idx_q == msg_len(cls_q) - 4'd1) begin
            msg_done_d   = 1'b1;
            byte_valid_d = 1'b0;
            if (GAP_CYCLES == 0) begin
              state_d = IDLE;
            end else begin
              state_d = GAP;
              gap_d   = GAP_LOAD;
            end
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      GAP: begin
        if (gap_q == '0) begin
          state_d = IDLE;
        end else begin
          gap_d = gap_q - GAP_W'(1);
        end
      end
      default: begin
        state_d      = IDLE;
        byte_valid_d = 1'b0;
      end
    endcase

    byte_data_d = byte_valid_d ? rom_byte : 8'h00;

    // A pulse landing on the grant cycle re-arms the flag with its new unit
    fim_pend_d = (fim_pend_q && !grant_fim) || fim_req;
    pbm_pend_d = (pbm_pend_q && !grant_pbm) || pbm_req;
    end_pend_d = (end_pend_q && !grant_end) || end_req;
    fim_unit_d = (fim_req && (!fim_pend_q || grant_fim)) ? fim_unit : fim_unit_q;
    pbm_unit_d = (pbm_req && (!pbm_pend_q || grant_pbm)) ? pbm_unit : pbm_unit_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cls_q        <= FIM;
      unit_q       <= 2'd0;
      idx_q        <= 4'd0;
      gap_q        <= '0;
      fim_pend_q   <= 1'b0;
      pbm_pend_q   <= 1'b0;
      end_pend_q   <= 1'b0;
      fim_unit_q   <= 2'd0;
      pbm_unit_q   <= 2'd0;
      byte_valid_q <= 1'b0;
      byte_data_q  <= 8'h00;
      fim_ack_q    <= 1'b0;
      pbm_ack_q    <= 1'b0;
      end_ack_q    <= 1'b0;
      msg_done_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cls_q        <= cls_d;
      unit_q       <= unit_d;
      idx_q        <= idx_d;
      gap_q        <= gap_d;
      fim_pend_q   <= fim_pend_d;
      pbm_pend_q   <= pbm_pend_d;
      end_pend_q   <= end_pend_d;
      fim_unit_q   <= fim_unit_d;
      pbm_unit_q   <= pbm_unit_d;
      byte_valid_q <= byte_valid_d;
      byte_data_q  <= byte_data_d;
      fim_ack_q    <= fim_ack_d;
      pbm_ack_q    <= pbm_ack_d;
      end_ack_q    <= end_ack_d;
      msg_done_q   <= msg_done_d;
    end
  end

`ifdef BT_SCHED_DROP_CNT_EN
  logic [7:0] drop_cnt_q, drop_cnt_d;
  logic [1:0] drop_num;
  logic [8:0] drop_sum;

  always_comb begin
    drop_num   = {1'b0, fim_req && fim_pend_q && !grant_fim}
               + {1'b0, pbm_req && pbm_pend_q && !grant_pbm}
               + {1'b0, end_req && end_pend_q && !grant_end};
    drop_sum   = {1'b0, drop_cnt_q} + {7'd0, drop_num};
    drop_cnt_d = drop_sum[8] ? 8'hFF : drop_sum[7:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt_q <= 8'h00;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_cnt = drop_cnt_q;
`endif

  assign fim_ack    = fim_ack_q;
  assign pbm_ack    = pbm_ack_q;
  assign end_ack    = end_ack_q;
  assign byte_valid = byte_valid_q;
  assign byte_data  = byte_data_q;
  assign msg_done   = msg_done_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_bt_msg_scheduler.sv
// Self-checking bench for bt_msg_scheduler: a queue-based message model is
// compared every cycle, plus literal byte streams and timing checks.
module tb_bt_msg_scheduler;

  localparam int         GAP   = 4;
  localparam logic [7:0] DIGIT = 8'h31;

  typedef logic [7:0] bq_t[$];

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       fim_req = 1'b0, pbm_req = 1'b0, end_req = 1'b0;
  logic [1:0] fim_unit = 2'd0, pbm_unit = 2'd0;
  logic       byte_ready = 1'b1;
  logic       fim_ack, pbm_ack, end_ack, byte_valid, busy, msg_done;
  logic [7:0] byte_data;
`ifdef BT_SCHED_DROP_CNT_EN
  logic [7:0] drop_cnt;
`endif

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  bq_t cap_q;
  int  ack_cyc[$];
  int  done_cyc[$];

  bq_t exp_fim0 = '{8'h46, 8'h49, 8'h4D, 8'h2D, 8'h43, 8'h53, 8'h55, 8'h31, 8'h2D, 8'h23};
  bq_t exp_fim1 = '{8'h46, 8'h49, 8'h4D, 8'h2D, 8'h43, 8'h53, 8'h55, 8'h32, 8'h2D, 8'h23};
  bq_t exp_fim2 = '{8'h46, 8'h49, 8'h4D, 8'h2D, 8'h43, 8'h53, 8'h55, 8'h33, 8'h2D, 8'h23};
  bq_t exp_pbm1 = '{8'h50, 8'h42, 8'h4D, 8'h2D, 8'h43, 8'h53, 8'h55, 8'h32, 8'h2D, 8'h23};
  bq_t exp_pbm2 = '{8'h50, 8'h42, 8'h4D, 8'h2D, 8'h43, 8'h53, 8'h55, 8'h33, 8'h2D, 8'h23};
  bq_t exp_end  = '{8'h45, 8'h4E, 8'h44, 8'h2D, 8'h23};

  // Model: 0 idle, 1 sending, 2 gap; classes indexed 0 FIM, 1 PBM, 2 END
  int         m_mode = 0;
  bq_t        m_bytes;
  int         m_pos = 0;
  int         m_gap = 0;
  bit         m_pend[3];
  logic [1:0] m_unit[3];
  bit         m_ack[3];
  bit         m_done = 1'b0;
  int         m_drops = 0;

  bt_msg_scheduler #(.GAP_CYCLES(GAP), .DIGIT_BASE(DIGIT)) dut (
    .clk       (clk),
    .rst       (rst),
    .fim_req   (fim_req),
    .fim_unit  (fim_unit),
    .pbm_req   (pbm_req),
    .pbm_unit  (pbm_unit),
    .end_req   (end_req),
    .fim_ack   (fim_ack),
    .pbm_ack   (pbm_ack),
    .end_ack   (end_ack),
    .byte_data (byte_data),
    .byte_valid(byte_valid),
    .byte_ready(byte_ready),
    .busy      (busy),
    .msg_done  (msg_done)
`ifdef BT_SCHED_DROP_CNT_EN
    ,
    .drop_cnt  (drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic bq_t build_msg(input int cls, input logic [1:0] unit);
    bq_t   q;
    string head;
    string tail;
    q = {};
    tail = "-#";
    if (cls == 0)      head = "FIM-CSU";
    else if (cls == 1) head = "PBM-CSU";
    else               head = "END-#";
    for (int i = 0; i < head.len(); i++) q.push_back(head[i]);
    if (cls != 2) begin
      q.push_back(DIGIT + {6'd0, unit});
      for (int i = 0; i < tail.len(); i++) q.push_back(tail[i]);
    end
    return q;
  endfunction

  task automatic model_reset();
    m_mode = 0;
    m_pos = 0;
    m_gap = 0;
    m_done = 1'b0;
    m_drops = 0;
    m_bytes = {};
    for (int i = 0; i < 3; i++) begin
      m_pend[i] = 1'b0;
      m_unit[i] = 2'd0;
      m_ack[i] = 1'b0;
    end
  endtask

  task automatic model_step();
    int         g;
    logic [2:0] req;
    logic [1:0] u[3];
    cyc++;
    g = -1;
    req = {end_req, pbm_req, fim_req};
    u[0] = fim_unit;
    u[1] = pbm_unit;
    u[2] = 2'd0;
    for (int i = 0; i < 3; i++) m_ack[i] = 1'b0;
    m_done = 1'b0;
    if (m_mode == 0) begin
      for (int i = 2; i >= 0; i--) if (m_pend[i]) g = i;
      if (g >= 0) begin
        m_bytes = build_msg(g, m_unit[g]);
        m_pos = 0;
        m_mode = 1;
        m_ack[g] = 1'b1;
        m_pend[g] = 1'b0;
      end
    end else if (m_mode == 1) begin
      if (byte_ready) begin
        m_pos++;
        if (m_pos == m_bytes.size()) begin
          m_done = 1'b1;
          m_gap = GAP;
          m_mode = (GAP > 0) ? 2 : 0;
        end
      end
    end else begin
      m_gap--;
      if (m_gap == 0) m_mode = 0;
    end
    for (int i = 0; i < 3; i++) begin
      if (req[i]) begin
        if (m_pend[i]) begin
          if (m_drops < 255) m_drops++;
        end else begin
          m_pend[i] = 1'b1;
          m_unit[i] = u[i];
        end
      end
    end
  endtask

  task automatic compare_step();
    logic [13:0] exp_v;
    logic [13:0] act_v;
    logic [7:0]  exp_d;
    exp_d = (m_mode == 1) ? m_bytes[m_pos] : 8'h00;
    exp_v = {m_ack[0], m_ack[1], m_ack[2], (m_mode == 1), exp_d, (m_mode != 0), m_done};
    act_v = {fim_ack, pbm_ack, end_ack, byte_valid, byte_data, busy, msg_done};
    checkOutput("cycle_outputs", 32'(act_v), 32'(exp_v));
`ifdef BT_SCHED_DROP_CNT_EN
    checkOutput("cycle_drop_cnt", 32'(drop_cnt), 32'(m_drops));
`endif
    if (fim_ack || pbm_ack || end_ack) ack_cyc.push_back(cyc);
    if (msg_done) done_cyc.push_back(cyc);
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) model_reset();
    else     model_step();
  end

  always @(posedge clk) begin
    if (!rst && byte_valid && byte_ready) cap_q.push_back(byte_data);
  end

  always @(negedge clk) compare_step();

  task automatic applyStimulus(input logic f, input logic [1:0] fu, input logic p,
                               input logic [1:0] pu, input logic e, input logic rdy);
    @(negedge clk);
    fim_req    = f;
    fim_unit   = fu;
    pbm_req    = p;
    pbm_unit   = pu;
    end_req    = e;
    byte_ready = rdy;
  endtask

  task automatic run_idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b1);
  endtask

  task automatic wait_bytes(input int n, input int budget);
    int c;
    c = 0;
    while (cap_q.size() < n && c < budget) begin
      applyStimulus(1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b1);
      c++;
    end
    checkOutput("wait_bytes_in_time", 32'(cap_q.size() >= n), 32'd1);
  endtask

  task automatic checkStream(input string name, input bq_t exp);
    checkOutput({name, "_len"}, cap_q.size(), exp.size());
    for (int i = 0; i < exp.size() && i < cap_q.size(); i++) checkOutput(name, cap_q[i], exp[i]);
  endtask

  task automatic clear_logs();
    cap_q.delete();
    ack_cyc.delete();
    done_cyc.delete();
  endtask

  initial begin
    bit pat[4];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset_valid", byte_valid, 1'b0);
    checkOutput("reset_data", byte_data, 8'h00);
    checkOutput("reset_busy", busy, 1'b0);
    checkOutput("reset_done", msg_done, 1'b0);
    checkOutput("reset_acks", {fim_ack, pbm_ack, end_ack}, 3'b000);
    rst = 1'b0;
    run_idle(2);

    $display("[TB] single FIM, unit 0");
    clear_logs();
    applyStimulus(1'b1, 2'd0, 1'b0, 2'd0, 1'b0, 1'b1);
    applyStimulus(1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("fim_ack_first", fim_ack, 1'b1);
    checkOutput("fim_first_valid", byte_valid, 1'b1);
    checkOutput("fim_first_byte", byte_data, 8'h46);
    run_idle(20);
    checkStream("fim_u0", exp_fim0);
    checkOutput("fim_done_count", done_cyc.size(), 1);
    if (done_cyc.size() >= 1 && ack_cyc.size() >= 1)
      checkOutput("fim_done_latency", done_cyc[0] - ack_cyc[0], 10);

    $display("[TB] simultaneous FIM/PBM/END priority");
    clear_logs();
    applyStimulus(1'b1, 2'd0, 1'b1, 2'd2, 1'b1, 1'b1);
    run_idle(50);
    checkStream("prio_order", {exp_fim0, exp_pbm2, exp_end});
    checkOutput("prio_ack_count", ack_cyc.size(), 3);
    if (done_cyc.size() >= 2 && ack_cyc.size() >= 3) begin
      checkOutput("gap_after_fim", ack_cyc[1] - done_cyc[0], GAP + 1);
      checkOutput("gap_after_pbm", ack_cyc[2] - done_cyc[1], GAP + 1);
    end

    $display("[TB] PBM with byte_ready stalls");
    clear_logs();
    applyStimulus(1'b0, 2'd0, 1'b1, 2'd2, 1'b0, 1'b1);
    for (int i = 0; i < 40; i++) applyStimulus(1'b0, 2'd0, 1'b0, 2'd0, 1'b0, pat[i % 4]);
    run_idle(10);
    checkStream("pbm_stall", exp_pbm2);

    $display("[TB] duplicate PBM request dropped");
    clear_logs();
    applyStimulus(1'b1, 2'd0, 1'b0, 2'd0, 1'b0, 1'b1);
    applyStimulus(1'b0, 2'd0, 1'b1, 2'd1, 1'b0, 1'b1);
    run_idle(2);
    applyStimulus(1'b0, 2'd0, 1'b1, 2'd3, 1'b0, 1'b1);
    run_idle(35);
    checkStream("pbm_drop", {exp_fim0, exp_pbm1});
`ifdef BT_SCHED_DROP_CNT_EN
    checkOutput("drop_cnt_one", drop_cnt, 8'd1);
`endif

    $display("[TB] FIM re-request on grant cycle");
    clear_logs();
    applyStimulus(1'b1, 2'd1, 1'b0, 2'd0, 1'b0, 1'b1);
    applyStimulus(1'b1, 2'd2, 1'b0, 2'd0, 1'b0, 1'b1);
    run_idle(35);
    checkStream("fim_regrant", {exp_fim1, exp_fim2});

    $display("[TB] reset mid-message");
    clear_logs();
    applyStimulus(1'b1, 2'd0, 1'b0, 2'd0, 1'b0, 1'b1);
    applyStimulus(1'b0, 2'd0, 1'b1, 2'd1, 1'b0, 1'b1);
    wait_bytes(3, 20);
    #2 rst = 1'b1;
    #1;
    checkOutput("rst_async_valid", byte_valid, 1'b0);
    checkOutput("rst_async_data", byte_data, 8'h00);
    checkOutput("rst_async_busy", busy, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    run_idle(20);
    checkOutput("rst_bytes_sent", cap_q.size(), 3);
    checkOutput("rst_no_new_ack", ack_cyc.size(), 1);
    checkOutput("rst_idle_busy", busy, 1'b0);
    checkOutput("rst_idle_valid", byte_valid, 1'b0);
`ifdef BT_SCHED_DROP_CNT_EN
    checkOutput("rst_drop_cnt", drop_cnt, 8'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule
